eth_axis_tx_framer: RTL



---
 rtl/eth_axis_tx_framer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/eth_axis_tx_framer.sv
// Buffered frame source streaming a stored frame into the MAC tx_axis port.
// Define ETH_TX_FRAMER_STATS_EN to build the frames_sent/frames_aborted counters.
module eth_axis_tx_framer #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int BUF_WORDS       = 512,
  parameter int LEN_WIDTH       = $clog2(BUF_WORDS * AXIS_KEEP_WIDTH) + 1
) (
  input  logic                         logic_clk,
  input  logic                         logic_rst_n,
  input  logic                         wr_v_i,
  input  logic [$clog2(BUF_WORDS)-1:0] wr_addr_i,
  input  logic [AXIS_DATA_WIDTH-1:0]   wr_data_i,
  input  logic                         send_v_i,
  input  logic [LEN_WIDTH-1:0]         send_len_i,
  input  logic                         abort_i,
  output logic                         send_ready_o,
  output logic                         tx_done_o,
  output logic                         wr_err_o,
  output logic                         send_err_o,
  output logic [AXIS_DATA_WIDTH-1:0]   tx_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]   tx_axis_tkeep,
  output logic                         tx_axis_tvalid,
  input  logic                         tx_axis_tready,
  output logic                         tx_axis_tlast,
  output logic                         tx_axis_tuser,
  output logic [15:0]                  frames_sent_o,
  output logic [15:0]                  frames_aborted_o
);

  localparam int AW  = $clog2(BUF_WORDS);
  localparam int BW  = LEN_WIDTH + 1;
  localparam int K   = AXIS_KEEP_WIDTH;
  localparam int CAP = BUF_WORDS * K;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
  state_t state_q, state_d;

  logic [AXIS_DATA_WIDTH-1:0] mem [BUF_WORDS];
  logic [AXIS_DATA_WIDTH-1:0] rd_data_q, fifo0_q, fifo1_q;
  logic                       rd_pend_q;
  logic [1:0]                 count_q;
  logic [BW-1:0]              beats_q, rd_idx_q, out_idx_q;
  logic [K-1:0]               last_keep_q;
  logic                       abort_q, head_term_q;
  logic                       wr_err_q, send_err_q;

  logic                 send_accept, wr_en, push, pop, issue, head_last, hs_last;
  logic                 abort_set, abort_next, head_load;
  logic [BW-1:0]        beats_calc;
  logic [LEN_WIDTH-1:0] rem;
  logic [K-1:0]         keep_calc;
  logic [2:0]           occ_after;

  always_comb begin
    send_accept = send_v_i && (state_q == S_IDLE) && (send_len_i != '0) &&
                  ({1'b0, send_len_i} <= BW'(CAP));
    wr_en       = wr_v_i && (state_q == S_IDLE) && !send_accept;
    beats_calc  = ({1'b0, send_len_i} + BW'(K - 1)) / BW'(K);
    rem         = send_len_i % LEN_WIDTH'(K);
    keep_calc   = '0;
    for (int unsigned i = 0; i < K; i++)
      keep_calc[i] = (rem == '0) || (LEN_WIDTH'(i) < rem);

    tx_axis_tvalid = (state_q == S_SEND) && (count_q != 2'd0);
    head_last      = (out_idx_q == beats_q - BW'(1));
    tx_axis_tdata  = fifo0_q;
    tx_axis_tlast  = tx_axis_tvalid && (head_last || head_term_q);
    tx_axis_tuser  = tx_axis_tvalid && (head_term_q || (head_last && abort_q));
    tx_axis_tkeep  = '0;
    if (tx_axis_tvalid) tx_axis_tkeep = head_last ? last_keep_q : '1;

    pop       = tx_axis_tvalid && tx_axis_tready;
    hs_last   = pop && tx_axis_tlast;
    push      = rd_pend_q && (state_q == S_SEND);
    // Reads in flight plus buffered words never exceed the two skid slots.
    occ_after = {1'b0, count_q} + 3'(rd_pend_q) - 3'(pop);
    issue     = (state_q == S_SEND) && (rd_idx_q < beats_q) && (occ_after < 3'd2);
    // An abort landing on the final handshake edge is too late to mark that beat.
    abort_set  = abort_i && (state_q == S_SEND) && !hs_last;
    abort_next = abort_q || abort_set;
    head_load  = pop || ((count_q == 2'd0) && push);
  end

  always_comb begin
    state_d      = state_q;
    send_ready_o = 1'b0;
    tx_done_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        send_ready_o = 1'b1;
        if (send_accept) state_d = S_SEND;
      end
      S_SEND: if (hs_last) state_d = S_DONE;
      S_DONE: begin
        tx_done_o = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (wr_en) mem[wr_addr_i] <= wr_data_i;
    if (issue) rd_data_q <= mem[rd_idx_q[AW-1:0]];
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q     <= S_IDLE;
      rd_pend_q   <= 1'b0;
      count_q     <= '0;
      fifo0_q     <= '0;
      fifo1_q     <= '0;
      beats_q     <= '0;
      rd_idx_q    <= '0;
      out_idx_q   <= '0;
      last_keep_q <= '0;
      abort_q     <= 1'b0;
      head_term_q <= 1'b0;
      wr_err_q    <= 1'b0;
      send_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= issue;
      wr_err_q   <= wr_v_i && !wr_en;
      send_err_q <= send_v_i && !send_accept;
      if (send_accept) begin
        beats_q     <= beats_calc;
        last_keep_q <= keep_calc;
        rd_idx_q    <= '0;
        out_idx_q   <= '0;
        abort_q     <= 1'b0;
        head_term_q <= 1'b0;
      end else begin
        if (issue) rd_idx_q <= rd_idx_q + BW'(1);
        if (pop) out_idx_q <= out_idx_q + BW'(1);
        if (abort_set) abort_q <= 1'b1;
        if (head_load) head_term_q <= abort_next;
      end
      if (state_q != S_SEND) begin
        count_q <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count_q == 2'd0) fifo0_q <= rd_data_q;
            else                 fifo1_q <= rd_data_q;
            count_q <= count_q + 2'd1;
          end
          2'b01: begin
            fifo0_q <= fifo1_q;
            count_q <= count_q - 2'd1;
          end
          2'b11: begin
            if (count_q == 2'd1) begin
              fifo0_q <= rd_data_q;
            end else begin
              fifo0_q <= fifo1_q;
              fifo1_q <= rd_data_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_err_o   = wr_err_q;
  assign send_err_o = send_err_q;

`ifdef ETH_TX_FRAMER_STATS_EN
  logic [15:0] sent_q, aborted_q;
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      sent_q    <= '0;
      aborted_q <= '0;
    end else if (state_q == S_DONE) begin
      if (abort_q) aborted_q <= aborted_q + 16'd1;
      else         sent_q    <= sent_q + 16'd1;
    end
  end
  assign frames_sent_o    = sent_q;
  assign frames_aborted_o = aborted_q;
`else
  assign frames_sent_o    = '0;
  assign frames_aborted_o = '0;
`endif

endmodule
